// File: rtl/frame_swap_scheduler.sv
// frame_swap_scheduler: double-buffered HUB75 frame RAM write sequencer and bank flipper.
// Optional FRAME_SWAP_TIMEOUT_EN adds an idle-timeout write pointer resync.
module frame_swap_scheduler #(
  parameter int ADDR_W = 11
`ifdef FRAME_SWAP_TIMEOUT_EN
  , parameter int IDLE_TIMEOUT = 65535
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_strobe_i,
  input  logic              wr_frame_start_i,
  input  logic              scan_frame_end_i,
  input  logic              overrun_clr_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              wr_bank_o,
  output logic              rd_bank_o,
  output logic              swap_pending_o,
  output logic              overrun_o,
  output logic [15:0]       dropped_count_o
);
  typedef enum logic [1:0] {FILL, WAIT_SWAP, SWAP} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d, base;
  logic              wr_en_q, wr_en_d, wr_bank_q, wr_bank_d, overrun_q, overrun_d;
  logic [15:0]       dropped_q, dropped_d;
  logic              accept, drop, resync, timeout;
`ifdef FRAME_SWAP_TIMEOUT_EN
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
  always_comb begin
    timeout = state_q == FILL && ptr_q != '0 && !wr_strobe_i && !wr_frame_start_i
              && idle_q == IW'(IDLE_TIMEOUT - 1);
    idle_d  = (state_q != FILL || ptr_q == '0 || wr_strobe_i || wr_frame_start_i || timeout)
              ? '0 : idle_q + 1'b1;
  end
  always_ff @(posedge clk) idle_q <= reset ? '0 : idle_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    accept    = state_q == FILL && wr_strobe_i;
    drop      = state_q != FILL && wr_strobe_i;
    resync    = state_q == FILL && (wr_frame_start_i || timeout);
    base      = resync ? '0 : ptr_q;
    ptr_d     = accept ? base + 1'b1 : base;
    wr_en_d   = accept;
    wr_addr_d = accept ? base : wr_addr_q;
    // Banks flip on the same edge that leaves WAIT_SWAP, so swap_pending and the banks change together.
    wr_bank_d = wr_bank_q ^ (state_q == WAIT_SWAP && scan_frame_end_i);
    overrun_d = drop | (overrun_q & ~overrun_clr_i);
    dropped_d = (drop && !(&dropped_q)) ? dropped_q + 1'b1 : dropped_q;
    state_d   = state_q;
    if (state_q == FILL && accept && &base) state_d = WAIT_SWAP;
    else if (state_q == WAIT_SWAP && scan_frame_end_i) state_d = SWAP;
    else if (state_q == SWAP) state_d = FILL;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FILL;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_bank_q <= 1'b1;
      overrun_q <= 1'b0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_bank_q <= wr_bank_d;
      overrun_q <= overrun_d;
      dropped_q <= dropped_d;
    end
  end
  assign wr_en_o         = wr_en_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_bank_o       = wr_bank_q;
  assign rd_bank_o       = ~wr_bank_q;
  assign swap_pending_o  = state_q == WAIT_SWAP;
  assign overrun_o       = overrun_q;
  assign dropped_count_o = dropped_q;
endmodule

// File: tb/tb_frame_swap_scheduler.sv
// tb_frame_swap_scheduler: directed self-checking bench for frame_swap_scheduler.
module tb_frame_swap_scheduler;
  localparam int ADDR_W = 11;
  localparam int NPIX = 1 << ADDR_W;
  logic clk = 0, reset = 1;
  logic wr_strobe = 0, wr_frame_start = 0, scan_frame_end = 0, overrun_clr = 0;
  logic wr_en, wr_bank, rd_bank, swap_pending, overrun;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0] dropped_count;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  frame_swap_scheduler #(
    .ADDR_W(ADDR_W)
`ifdef FRAME_SWAP_TIMEOUT_EN
    , .IDLE_TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .reset(reset), .wr_strobe_i(wr_strobe), .wr_frame_start_i(wr_frame_start),
    .scan_frame_end_i(scan_frame_end), .overrun_clr_i(overrun_clr), .wr_en_o(wr_en),
    .wr_addr_o(wr_addr), .wr_bank_o(wr_bank), .rd_bank_o(rd_bank),
    .swap_pending_o(swap_pending), .overrun_o(overrun), .dropped_count_o(dropped_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic strobes(input int n, input int first_addr, input logic bank, output int errs);
    errs = 0;
    for (int i = 0; i < n; i++) begin
      wr_strobe = 1;
      tick();
      if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(first_addr + i) || wr_bank !== bank) errs++;
    end
    wr_strobe = 0;
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_bank"}, wr_bank, 1);
    chk({tag, "_rd_bank"}, rd_bank, 0);
    chk({tag, "_swap_pending"}, swap_pending, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_dropped"}, dropped_count, 0);
  endtask
  initial begin
    int errs;
    tick(); tick();
    reset = 0;
    chk_reset_state("rst");
    strobes(NPIX - 1, 0, 1'b1, errs);
    chk("frame_writes", errs, 0);
    chk("pending_before_last", swap_pending, 0);
    strobes(1, NPIX - 1, 1'b1, errs);
    chk("last_write", errs, 0);
    chk("pending_after_last", swap_pending, 1);
    tick();
    chk("wr_en_single_cycle", wr_en, 0);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      wr_strobe = 1;
      tick();
      if (wr_en !== 1'b0) errs++;
    end
    wr_strobe = 0;
    chk("drop_no_wr_en", errs, 0);
    chk("overrun_set", overrun, 1);
    chk("dropped_5", dropped_count, 5);
    chk("pending_held", swap_pending, 1);
    overrun_clr = 1; tick(); overrun_clr = 0;
    chk("overrun_cleared", overrun, 0);
    chk("dropped_kept", dropped_count, 5);
    wr_strobe = 1; overrun_clr = 1; tick(); wr_strobe = 0; overrun_clr = 0;
    chk("set_beats_clr", overrun, 1);
    chk("dropped_6", dropped_count, 6);
    overrun_clr = 1; tick(); overrun_clr = 0;
    chk("overrun_cleared2", overrun, 0);
    scan_frame_end = 1; tick(); scan_frame_end = 0;
    chk("swap_wr_bank", wr_bank, 0);
    chk("swap_rd_bank", rd_bank, 1);
    chk("swap_pending_fall", swap_pending, 0);
    wr_strobe = 1; tick();
    chk("swap_cycle_drop_wr_en", wr_en, 0);
    chk("swap_cycle_dropped", dropped_count, 7);
    chk("swap_cycle_overrun", overrun, 1);
    tick(); wr_strobe = 0;
    chk("gap2_wr_en", wr_en, 1);
    chk("gap2_addr", wr_addr, 0);
    chk("gap2_bank", wr_bank, 0);
    strobes(99, 1, 1'b0, errs);
    chk("resync_prefill", errs, 0);
    wr_frame_start = 1; wr_strobe = 1; tick(); wr_frame_start = 0; wr_strobe = 0;
    chk("resync_coincident_en", wr_en, 1);
    chk("resync_coincident_addr", wr_addr, 0);
    strobes(1, 1, 1'b0, errs);
    chk("resync_next_addr1", errs, 0);
    wr_frame_start = 1; tick(); wr_frame_start = 0;
    chk("resync_alone_no_write", wr_en, 0);
    strobes(1, 0, 1'b0, errs);
    chk("resync_alone_addr0", errs, 0);
    scan_frame_end = 1; tick(); scan_frame_end = 0;
    chk("sfe_in_fill_bank", wr_bank, 0);
    chk("sfe_in_fill_pending", swap_pending, 0);
    strobes(NPIX - 2, 1, 1'b0, errs);
    chk("fill_to_last", errs, 0);
    wr_strobe = 1; scan_frame_end = 1; tick(); wr_strobe = 0; scan_frame_end = 0;
    chk("coinc_last_addr", wr_addr, NPIX - 1);
    chk("coinc_pending", swap_pending, 1);
    chk("coinc_no_flip", wr_bank, 0);
    wr_frame_start = 1; tick(); wr_frame_start = 0;
    chk("fs_ignored_pending", swap_pending, 1);
    chk("fs_ignored_bank", wr_bank, 0);
    scan_frame_end = 1; tick(); scan_frame_end = 0;
    chk("coinc_flip_wr", wr_bank, 1);
    chk("coinc_flip_rd", rd_bank, 0);
    tick();
    strobes(700, 0, 1'b1, errs);
    chk("midframe_writes", errs, 0);
    reset = 1; tick(); reset = 0;
    chk_reset_state("midrst");
    strobes(1, 0, 1'b1, errs);
    chk("after_reset_addr0", errs, 0);
    wr_frame_start = 1; tick(); wr_frame_start = 0;
    strobes(10, 0, 1'b1, errs);
    chk("timeout_prefill", errs, 0);
    for (int i = 0; i < 16; i++) tick();
    wr_strobe = 1; tick(); wr_strobe = 0;
    chk("timeout_wr_en", wr_en, 1);
`ifdef FRAME_SWAP_TIMEOUT_EN
    chk("timeout_addr", wr_addr, 0);
`else
    chk("timeout_addr", wr_addr, 10);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
